// File: rtl/fft16_sequencer.sv
// Control sequencer for a 16-point radix-2 DIT FFT: bit-reversed load, 4x8 butterfly
// issue with twiddle addressing, and a pipeline drain gap after every stage.
module fft16_sequencer #(
    parameter int unsigned BF_LAT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic [3:0] sample_addr,
    output logic       load_we,
    output logic [3:0] load_waddr,
    output logic       bf_valid,
    output logic [3:0] addr_a,
    output logic [3:0] addr_b,
    output logic [2:0] tw_addr,
    output logic [1:0] stage
);

    localparam int unsigned NW = 4;
    localparam int unsigned JW = 3;
    localparam int unsigned DW = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_COMPUTE = 3'd2,
        S_DRAIN   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [JW-1:0] j_q, j_d;
    logic [1:0]    stage_q, stage_d;
    logic [DW-1:0] drain_q, drain_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load_we_q, load_we_d;
    logic          bf_valid_q, bf_valid_d;
    logic [NW-1:0] load_waddr_q, load_waddr_d;
    logic [NW-1:0] addr_a_q, addr_a_d;
    logic [NW-1:0] addr_b_q, addr_b_d;
    logic [2:0]    tw_q, tw_d;

    logic          stall_act;
    logic [NW-1:0] span, pos, a_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            j_q          <= '0;
            stage_q      <= '0;
            drain_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            load_we_q    <= 1'b0;
            bf_valid_q   <= 1'b0;
            load_waddr_q <= '0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            tw_q         <= '0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            j_q          <= j_d;
            stage_q      <= stage_d;
            drain_q      <= drain_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            load_we_q    <= load_we_d;
            bf_valid_q   <= bf_valid_d;
            load_waddr_q <= load_waddr_d;
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            tw_q         <= tw_d;
        end
    end

    // Next state and counters; stall freezes everything in the busy states.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        j_d       = j_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        stall_act = stall && (state_q == S_LOAD || state_q == S_COMPUTE || state_q == S_DRAIN);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    n_d     = '0;
                end
            end
            S_LOAD: begin
                if (!stall) begin
                    if (n_q == NW'(15)) begin
                        state_d = S_COMPUTE;
                        stage_d = '0;
                        j_d     = '0;
                    end else begin
                        n_d = n_q + NW'(1);
                    end
                end
            end
            S_COMPUTE: begin
                if (!stall) begin
                    if (j_q == JW'(7)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        j_d = j_q + JW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (drain_q == DW'(BF_LAT - 1)) begin
                        if (stage_q == 2'd3) begin
                            state_d = S_DONE;
                            stage_d = '0;
                        end else begin
                            state_d = S_COMPUTE;
                            stage_d = stage_q + 2'd1;
                            j_d     = '0;
                        end
                    end else begin
                        drain_d = drain_q + DW'(1);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Butterfly operand and twiddle addresses for (stage_d, j_d).
    always_comb begin
        span  = NW'(1) << stage_d;
        pos   = NW'(j_d) & (span - NW'(1));
        a_nxt = ((NW'(j_d) >> stage_d) << (3'(stage_d) + 3'd1)) | pos;
    end

    // Registered outputs follow the state being entered; addresses hold when no strobe.
    always_comb begin
        busy_d       = (state_d == S_LOAD) || (state_d == S_COMPUTE) || (state_d == S_DRAIN);
        done_d       = (state_d == S_DONE);
        load_we_d    = (state_d == S_LOAD) && !stall_act;
        bf_valid_d   = (state_d == S_COMPUTE) && !stall_act;
        load_waddr_d = load_waddr_q;
        addr_a_d     = addr_a_q;
        addr_b_d     = addr_b_q;
        tw_d         = tw_q;
        if (load_we_d) begin
            load_waddr_d = {n_d[0], n_d[1], n_d[2], n_d[3]};
        end
        if (bf_valid_d) begin
            addr_a_d = a_nxt;
            addr_b_d = a_nxt + span;
            tw_d     = 3'(pos) << (2'd3 - stage_d);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign sample_addr = n_q;
    assign load_we     = load_we_q;
    assign load_waddr  = load_waddr_q;
    assign bf_valid    = bf_valid_q;
    assign addr_a      = addr_a_q;
    assign addr_b      = addr_b_q;
    assign tw_addr     = tw_q;
    assign stage       = stage_q;

endmodule

// File: tb/tb_fft16_sequencer.sv
// Self-checking bench for fft16_sequencer: per-cycle comparison against a work-item
// queue model, plus fixed spot checks of load order, addresses and done timing.
module tb_fft16_sequencer;

    localparam int NE = 150;
    localparam int K_IDLE = 0, K_LOAD = 1, K_BF = 2, K_DRAIN = 3, K_DONE = 4;

    typedef struct {
        int kind;
        int n;
        int s;
        int a;
        int b;
        int tw;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, start2, start5, stall;

    logic       busy2, done2, we2, bv2, busy5, done5, we5, bv5;
    logic [3:0] sa2, lw2, a2, b2, sa5, lw5, a5, b5;
    logic [2:0] tw2, tw5;
    logic [1:0] st2, st5;
    logic [24:0] obs2, obs5;

    fft16_sequencer #(.BF_LAT(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start2), .stall(stall),
        .busy(busy2), .done(done2), .sample_addr(sa2), .load_we(we2), .load_waddr(lw2),
        .bf_valid(bv2), .addr_a(a2), .addr_b(b2), .tw_addr(tw2), .stage(st2)
    );

    fft16_sequencer #(.BF_LAT(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .stall(stall),
        .busy(busy5), .done(done5), .sample_addr(sa5), .load_we(we5), .load_waddr(lw5),
        .bf_valid(bv5), .addr_a(a5), .addr_b(b5), .tw_addr(tw5), .stage(st5)
    );

    assign obs2 = {busy2, done2, we2, bv2, st2, sa2, lw2, a2, b2, tw2};
    assign obs5 = {busy5, done5, we5, bv5, st5, sa5, lw5, a5, b5, tw5};

    bit          start_e [NE];
    bit          stall_e [NE];
    logic [24:0] exp_v   [NE];
    logic [24:0] obs_v   [NE];
    item_t       q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic int bitrev4(input int n);
        int r = 0;
        for (int i = 0; i < 4; i++) r = r | (((n >> i) & 1) << (3 - i));
        return r;
    endfunction

    // Expected outputs after each edge: a transform is a list of one-cycle work items.
    task automatic build_model(input int lat);
        int cur, m_sa, m_lw, m_a, m_b, m_tw, m_st, span;
        bit we, bv, busy_now, take;
        item_t it;
        cur = K_IDLE; m_sa = 0; m_lw = 0; m_a = 0; m_b = 0; m_tw = 0; m_st = 0;
        q.delete();
        for (int e = 0; e < NE; e++) begin
            we = 0; bv = 0; take = 0;
            busy_now = (cur == K_LOAD) || (cur == K_BF) || (cur == K_DRAIN);
            if (busy_now && stall_e[e]) begin
                take = 0;
            end else if (q.size() > 0) begin
                take = 1;
            end else if (cur == K_IDLE && start_e[e]) begin
                for (int n = 0; n < 16; n++) q.push_back('{K_LOAD, n, 0, 0, 0, 0});
                for (int s = 0; s < 4; s++) begin
                    span = 1 << s;
                    for (int g = 0; g < 8 / span; g++)
                        for (int p = 0; p < span; p++)
                            q.push_back('{K_BF, 0, s, g * 2 * span + p, g * 2 * span + p + span, p * (8 / span)});
                    for (int d = 0; d < lat; d++) q.push_back('{K_DRAIN, 0, s, 0, 0, 0});
                end
                q.push_back('{K_DONE, 0, 0, 0, 0, 0});
                take = 1;
            end else begin
                cur = K_IDLE;
            end
            if (take) begin
                it  = q.pop_front();
                cur = it.kind;
                case (it.kind)
                    K_LOAD:  begin m_sa = it.n; m_lw = bitrev4(it.n); we = 1; m_st = 0; end
                    K_BF:    begin m_a = it.a; m_b = it.b; m_tw = it.tw; bv = 1; m_st = it.s; end
                    K_DRAIN: m_st = it.s;
                    default: m_st = 0;
                endcase
            end
            busy_now = (cur == K_LOAD) || (cur == K_BF) || (cur == K_DRAIN);
            exp_v[e] = {busy_now, cur == K_DONE, we, bv, 2'(m_st), 4'(m_sa), 4'(m_lw),
                        4'(m_a), 4'(m_b), 3'(m_tw)};
        end
    endtask

    task automatic clear_stim();
        for (int e = 0; e < NE; e++) begin
            start_e[e] = 0;
            stall_e[e] = 0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; start2 = 1'b0; start5 = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive inputs for edge e on the preceding negedge, record outputs after the edge.
    task automatic run_dut(input bit use5);
        for (int e = 0; e < NE; e++) begin
            start2 = use5 ? 1'b0 : start_e[e];
            start5 = use5 ? start_e[e] : 1'b0;
            stall  = stall_e[e];
            @(posedge clk);
            @(negedge clk);
            obs_v[e] = use5 ? obs5 : obs2;
        end
        start2 = 1'b0; start5 = 1'b0; stall = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start2 = 1'b0; start5 = 1'b0; stall = 1'b0;
        #1;
        checks++;
        if (obs2 !== 25'd0) begin errors++; $display("FAIL reset_lat2 got=%h exp=0", obs2); end
        checks++;
        if (obs5 !== 25'd0) begin errors++; $display("FAIL reset_lat5 got=%h exp=0", obs5); end
        do_reset();
    endtask

    task automatic test_nominal();
        int lw_seq [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        int ne [5] = '{19, 31, 42, 49, 53};
        logic [10:0] na [5] = '{{4'd6, 4'd7, 3'd0}, {4'd9, 4'd11, 3'd4}, {4'd10, 4'd14, 3'd4},
                               {4'd3, 4'd11, 3'd3}, {4'd7, 4'd15, 3'd7}};
        int nbv = 0, done_at = -1;
        do_reset();
        clear_stim();
        start_e[0] = 1;
        build_model(2);
        run_dut(0);
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++; $display("FAIL nominal_cycle%0d got=%h exp=%h", e + 1, obs_v[e], exp_v[e]);
            end
            if (obs_v[e][21]) nbv++;
            if (obs_v[e][23] && done_at < 0) done_at = e + 1;
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (obs_v[i][22] !== 1'b1 || obs_v[i][14:11] !== 4'(lw_seq[i])) begin
                errors++; $display("FAIL load_order_cycle%0d got_we=%b got=%0d exp=%0d", i + 1, obs_v[i][22], obs_v[i][14:11], lw_seq[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (obs_v[ne[i]][21] !== 1'b1 || obs_v[ne[i]][10:0] !== na[i]) begin
                errors++; $display("FAIL bf_addr_cycle%0d got=%h exp=%h", ne[i] + 1, obs_v[ne[i]][10:0], na[i]);
            end
        end
        checks++;
        if (nbv != 32) begin errors++; $display("FAIL bf_count got=%0d exp=32", nbv); end
        checks++;
        if (done_at != 57) begin errors++; $display("FAIL done_cycle got=%0d exp=57", done_at); end
    endtask

    task automatic test_stall();
        int done_at = -1;
        do_reset();
        clear_stim();
        start_e[0] = 1;
        stall_e[6] = 1; stall_e[7] = 1; stall_e[8] = 1;
        stall_e[40] = 1; stall_e[41] = 1;
        build_model(2);
        run_dut(0);
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++; $display("FAIL stall_cycle%0d got=%h exp=%h", e + 1, obs_v[e], exp_v[e]);
            end
            if (obs_v[e][23] && done_at < 0) done_at = e + 1;
        end
        checks++;
        if (obs_v[7][22] !== 1'b0 || obs_v[7][18:15] !== 4'd5 || obs_v[7][14:11] !== 4'd10) begin
            errors++; $display("FAIL stall_load_hold got=%h exp_we=0 sa=5 lw=10", obs_v[7]);
        end
        checks++;
        if (done_at != 62) begin errors++; $display("FAIL stall_done_cycle got=%0d exp=62", done_at); end
    endtask

    task automatic test_start_ignored();
        int ndone = 0, done_at = -1;
        do_reset();
        clear_stim();
        start_e[0] = 1; start_e[10] = 1; start_e[40] = 1;
        build_model(2);
        run_dut(0);
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++; $display("FAIL ign_start_cycle%0d got=%h exp=%h", e + 1, obs_v[e], exp_v[e]);
            end
            if (obs_v[e][23]) begin ndone++; if (done_at < 0) done_at = e + 1; end
        end
        checks++;
        if (ndone != 1 || done_at != 57) begin
            errors++; $display("FAIL ign_start_done got=%0d@%0d exp=1@57", ndone, done_at);
        end
    endtask

    task automatic test_back_to_back();
        int ndone = 0, last_done = -1;
        do_reset();
        clear_stim();
        start_e[0] = 1; start_e[57] = 1; start_e[58] = 1;
        build_model(2);
        run_dut(0);
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++; $display("FAIL b2b_cycle%0d got=%h exp=%h", e + 1, obs_v[e], exp_v[e]);
            end
            if (obs_v[e][23]) begin ndone++; last_done = e + 1; end
        end
        checks++;
        if (ndone != 2 || last_done != 115) begin
            errors++; $display("FAIL b2b_done got=%0d@%0d exp=2@115", ndone, last_done);
        end
    endtask

    task automatic test_reset_midrun();
        int done_at = -1;
        do_reset();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (29) @(negedge clk);
        checks++;
        if (bv2 !== 1'b1 || st2 !== 2'd1) begin
            errors++; $display("FAIL midrun_before_reset got_bv=%b stage=%0d exp 1/1", bv2, st2);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs2 !== 25'd0) begin errors++; $display("FAIL midrun_reset got=%h exp=0", obs2); end
        do_reset();
        clear_stim();
        start_e[0] = 1;
        build_model(2);
        run_dut(0);
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++; $display("FAIL after_reset_cycle%0d got=%h exp=%h", e + 1, obs_v[e], exp_v[e]);
            end
            if (obs_v[e][23] && done_at < 0) done_at = e + 1;
        end
        checks++;
        if (done_at != 57) begin errors++; $display("FAIL after_reset_done got=%0d exp=57", done_at); end
    endtask

    task automatic test_lat5();
        int done_at = -1;
        do_reset();
        clear_stim();
        start_e[0] = 1;
        build_model(5);
        run_dut(1);
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (obs_v[e] !== exp_v[e]) begin
                errors++; $display("FAIL lat5_cycle%0d got=%h exp=%h", e + 1, obs_v[e], exp_v[e]);
            end
            if (obs_v[e][23] && done_at < 0) done_at = e + 1;
        end
        checks++;
        if (done_at != 69) begin errors++; $display("FAIL lat5_done got=%0d exp=69", done_at); end
    endtask

    task automatic test_random();
        bit use5;
        for (int it = 0; it < 6; it++) begin
            use5 = it[0];
            do_reset();
            clear_stim();
            start_e[0] = 1;
            for (int e = 1; e < NE; e++) begin
                stall_e[e] = ($urandom_range(3) == 0);
                start_e[e] = ($urandom_range(15) == 0);
            end
            build_model(use5 ? 5 : 2);
            run_dut(use5);
            for (int e = 0; e < NE; e++) begin
                checks++;
                if (obs_v[e] !== exp_v[e]) begin
                    errors++; $display("FAIL random%0d_cycle%0d got=%h exp=%h", it, e + 1, obs_v[e], exp_v[e]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_midrun();
        test_lat5();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
